// File: rtl/queue_serializer_pkg.sv
// Shared constants for the queue serializer: FSM state encoding and the
// width of the completed-word counter.
package queue_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int WORD_COUNT_WIDTH = 16;

endpackage

// File: rtl/queue_serializer.sv
// Pops one WIDTH-bit word from an upstream queue and emits it as
// WIDTH/OUT_WIDTH chunks over a valid/ready stream, counting finished words.
module queue_serializer
  import queue_serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [WIDTH-1:0]            Data_In,
  input  logic                        InputValid,
  output logic                        ConsumerBusy,
  output logic [OUT_WIDTH-1:0]        Data_Out,
  output logic                        OutputValid,
  input  logic                        DownstreamReady,
  output logic                        LastChunk,
  output logic [WORD_COUNT_WIDTH-1:0] WordCount
);

  localparam int N     = WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            word_q;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            sel;
  logic [WORD_COUNT_WIDTH-1:0] count_q;
  logic                        pop;
  logic                        xfer;
  logic                        at_last;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs come from the state register only, never from inputs.
  always_comb begin
    state_d      = state_q;
    ConsumerBusy = 1'b0;
    OutputValid  = 1'b0;
    LastChunk    = 1'b0;
    pop          = 1'b0;
    xfer         = 1'b0;
    at_last      = (idx_q == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (InputValid) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        ConsumerBusy = 1'b1;
        OutputValid  = 1'b1;
        LastChunk    = at_last;
        if (DownstreamReady) begin
          xfer = 1'b1;
          if (at_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        word_q <= Data_In;
        idx_q  <= '0;
      end else if (xfer) begin
        if (at_last) begin
          count_q <= count_q + 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  // Chunk order is reversed by remapping the index rather than the word.
  always_comb begin
    sel      = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    Data_Out = word_q[sel*OUT_WIDTH +: OUT_WIDTH];
  end

  assign WordCount = count_q;

endmodule

// File: doc/queue_serializer.md
QUEUE_SERIALIZER -- requirements
Module: queue_serializer

Interface
REQ-001 Parameter WIDTH, default 32, width of queue word consumed.
REQ-002 Parameter OUT_WIDTH, default 8, width of each emitted chunk; WIDTH SHALL be an integer multiple of OUT_WIDTH with WIDTH/OUT_WIDTH >= 2.
REQ-003 Parameter MSB_FIRST, default 0; 0 = least-significant chunk first, 1 = most-significant chunk first.
REQ-004 Clock  input  1  single clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 Data_In  input  WIDTH  word presented by upstream queue.
REQ-007 InputValid  input  1  upstream holds a valid word on Data_In.
REQ-008 ConsumerBusy  output  1  high = do not pop; low = word on Data_In is taken this edge if InputValid.
REQ-009 Data_Out  output  OUT_WIDTH  current chunk.
REQ-010 OutputValid  output  1  Data_Out holds a valid chunk.
REQ-011 DownstreamReady  input  1  sink accepts chunk this edge.
REQ-012 LastChunk  output  1  high with OutputValid on the final chunk of a word.
REQ-013 WordCount  output  16  count of words fully emitted, modulo 2^16.

Function
REQ-014 Chunk transfer SHALL occur on an edge where OutputValid=1 and DownstreamReady=1; word pop SHALL occur on an edge where InputValid=1 and ConsumerBusy=0.
REQ-015 FSM states: IDLE, SEND; ConsumerBusy SHALL be 0 in IDLE and 1 in SEND, decoded from the state register only (no combinational path from any input).
REQ-016 IDLE: if InputValid, latch Data_In into word register, clear chunk index, go to SEND; else remain IDLE.
REQ-017 SEND: OutputValid=1; Data_Out = chunk selected by index (index 0 = bits [OUT_WIDTH-1:0] when MSB_FIRST=0, top chunk when MSB_FIRST=1).
REQ-018 SEND with DownstreamReady=0: hold index, Data_Out, OutputValid, LastChunk stable.
REQ-019 SEND with DownstreamReady=1 and index < N-1 (N = WIDTH/OUT_WIDTH): index increments.
REQ-020 SEND with DownstreamReady=1 and index = N-1: WordCount increments (wraps 0xFFFF -> 0x0000), return to IDLE.
REQ-021 Latency: word popped at edge k SHALL present first chunk valid in the cycle after edge k; with DownstreamReady held 1, one word SHALL take N+1 cycles (N chunks plus one IDLE pop cycle).
REQ-022 Data_In changes while in SEND SHALL not affect the latched word.
REQ-023 OutputValid, LastChunk SHALL be 0 in IDLE; Data_Out is don't-care when OutputValid=0.

Reset
REQ-024 Reset=0 SHALL immediately force IDLE, index 0, word register 0, WordCount 0, OutputValid 0, LastChunk 0, ConsumerBusy 0.
REQ-025 Reset asserted mid-word SHALL discard the partially sent word without incrementing WordCount; the word is not re-requested.
REQ-026 After Reset deasserts, first pop SHALL occur on the first edge with InputValid=1.

Structure
REQ-027 State encodings (IDLE, SEND) and the WordCount width constant SHALL live in the shared header with the other datapath constants.
REQ-028 Single module; no sub-module; chunk index width = $clog2(WIDTH/OUT_WIDTH).

Verification
REQ-029 Defaults, Data_In=0xAABBCCDD, InputValid pulsed 1 cycle, DownstreamReady=1 -> Data_Out 0xDD,0xCC,0xBB,0xAA on 4 consecutive cycles, LastChunk only with 0xAA, WordCount 0->1.
REQ-030 MSB_FIRST=1, same word -> 0xAA,0xBB,0xCC,0xDD.
REQ-031 DownstreamReady low 3 cycles during chunk 2 -> Data_Out=0xBB held stable, ConsumerBusy=1 throughout, no extra pops.
REQ-032 InputValid held 1 with words 0x11111111,0x22222222 back-to-back, sink always ready -> 10 cycles for both, exactly 2 pops, WordCount=2.
REQ-033 Reset pulled low after chunk 1 of a word -> outputs zero immediately, WordCount stays 0, next word emitted from chunk 0.
REQ-034 Preload WordCount to 0xFFFF via 65535 words (or force), send one more -> WordCount=0x0000.
